sqnxt_l1_to_l17: RTL and testbench

//  Self-contained SqueezeNext-style inference core that runs layers 1..17 back-to-back
//  on a built-in 16-channel int8 input vector, using built-in ternary weights.

---
 rtl/sqnxt_l1_to_l17.sv | 87 ++++++++
 tb/tb_sqnxt_l1_to_l17.sv | 128 ++++++++++++
 2 files changed

// File: rtl/sqnxt_l1_to_l17.sv
// sqnxt_l1_to_l17: self-starting ternary-weight 16-channel int8 core running layers 1..NUM_LAYERS.
// One output channel per clock, ping-ponging between two activation banks.
module sqnxt_l1_to_l17 #(
  parameter int NUM_LAYERS = 17,
  parameter int CH = 16
) (
  input  logic            clk,
  input  logic            rst,
  output logic [8*CH-1:0] out1_layer17,
  output logic [8*CH-1:0] out2_layer17
);
  typedef enum logic {RUN, DONE} state_t;
  localparam int CW = $clog2(CH);
  function automatic logic [8*CH-1:0] init_vec();
    logic [8*CH-1:0] v;
    for (int c = 0; c < CH; c++) v[8*c +: 8] = 8'(c + 1);
    return v;
  endfunction
  localparam logic [8*CH-1:0] X_INIT = init_vec();
  state_t            state_q, state_d;
  logic [4:0]        layer_q, layer_d;
  logic [CW-1:0]     ch_q, ch_d;
  logic              sel_q, sel_d;
  logic [8*CH-1:0]   a_q, a_d, b_q, b_d, out1_q, out1_d, out2_q, out2_d, rd, wr;
  logic signed [12:0] acc;
  logic [1:0]        w;
  logic [7:0]        y;
  always_comb begin
    rd = sel_q ? b_q : a_q;
    // w tracks (layer+ch+i) mod 3; weight is w-1
    w = 2'((6'(layer_q) + 6'(ch_q)) % 6'd3);
    acc = '0;
    for (int i = 0; i < CH; i++) begin
      acc = w == 2'd2 ? acc + 13'(rd[8*i +: 7]) : w == 2'd0 ? acc - 13'(rd[8*i +: 7]) : acc;
      w = w == 2'd2 ? 2'd0 : w + 2'd1;
    end
    y = acc < 13'sd0 ? 8'd0 : acc > 13'sd127 ? 8'd127 : acc[7:0];
    wr = sel_q ? a_q : b_q;
    wr[8*ch_q +: 8] = y;
    state_d = state_q;
    layer_d = layer_q;
    ch_d = ch_q;
    sel_d = sel_q;
    a_d = a_q;
    b_d = b_q;
    out1_d = out1_q;
    out2_d = out2_q;
    if (state_q == RUN) begin
      a_d = sel_q ? wr : a_q;
      b_d = sel_q ? b_q : wr;
      ch_d = ch_q + 1'b1;
      if (ch_q == CW'(CH - 1)) begin
        sel_d = ~sel_q;
        layer_d = layer_q + 5'd1;
        if (layer_q == 5'(NUM_LAYERS)) begin
          state_d = DONE;
          layer_d = layer_q;
          out1_d = wr;
          out2_d = rd;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      layer_q <= 5'd1;
      ch_q    <= '0;
      sel_q   <= 1'b0;
      a_q     <= X_INIT;
      b_q     <= '0;
      out1_q  <= '0;
      out2_q  <= '0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      ch_q    <= ch_d;
      sel_q   <= sel_d;
      a_q     <= a_d;
      b_q     <= b_d;
      out1_q  <= out1_d;
      out2_q  <= out2_d;
    end
  end
  assign out1_layer17 = out1_q;
  assign out2_layer17 = out2_q;
endmodule

// File: tb/tb_sqnxt_l1_to_l17.sv
// tb_sqnxt_l1_to_l17: checks the 17-layer core and a 1-layer instance against an
// integer-array reference model, with randomized reset timing.
module tb_sqnxt_l1_to_l17;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [127:0] o1, o2, p1, p2, g1, g2, h1, h2;
  int checks = 0;
  int errors = 0;
  localparam logic [127:0] ONE_OUT2 = 128'h100F0E0D0C0B0A090807060504030201;
  localparam logic [127:0] ONE_OUT1 = 128'h00000B00000B00000B00000B00000B00;
  localparam logic [127:0] BIT7 = {16{8'h80}};

  sqnxt_l1_to_l17 u_dut (.clk(clk), .rst(rst), .out1_layer17(o1), .out2_layer17(o2));
  sqnxt_l1_to_l17 #(.NUM_LAYERS(1)) u_one (.clk(clk), .rst(rst), .out1_layer17(p1), .out2_layer17(p2));

  always #50 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model(input int n, output logic [127:0] r1, output logic [127:0] r2);
    int a[16];
    int b[16];
    int acc;
    r1 = '0;
    r2 = '0;
    for (int c = 0; c < 16; c++) a[c] = c + 1;
    for (int l = 1; l <= n; l++) begin
      for (int o = 0; o < 16; o++) begin
        acc = 0;
        for (int i = 0; i < 16; i++) acc += (((l + o + i) % 3) - 1) * a[i];
        b[o] = acc < 0 ? 0 : (acc > 127 ? 127 : acc);
      end
      if (l == n)
        for (int c = 0; c < 16; c++) begin
          r2[8*c +: 8] = 8'(a[c]);
          r1[8*c +: 8] = 8'(b[c]);
        end
      for (int c = 0; c < 16; c++) a[c] = b[c];
    end
  endfunction

  task automatic run_check(input string tag);
    for (int k = 1; k <= 272; k++) begin
      @(posedge clk);
      #1;
      if (k < 272) begin
        chk({tag, "_zero1"}, o1, '0);
        chk({tag, "_zero2"}, o2, '0);
      end else begin
        chk({tag, "_out1"}, o1, g1);
        chk({tag, "_out2"}, o2, g2);
      end
    end
  endtask

  initial begin
    int n;
    model(17, g1, g2);
    model(1, h1, h2);
    chk("one_model_out1", h1, ONE_OUT1);
    chk("one_model_out2", h2, ONE_OUT2);
    // scenario 1: held in reset for 100 ns
    #100;
    @(negedge clk);
    chk("rst_out1", o1, '0);
    chk("rst_out2", o2, '0);
    chk("rst_one_out1", p1, '0);
    chk("rst_one_out2", p2, '0);
    // scenarios 2 and 3
    rst = 1'b1;
    for (int k = 1; k <= 272; k++) begin
      @(posedge clk);
      #1;
      chk("one_out1", p1, k < 16 ? 128'h0 : ONE_OUT1);
      chk("one_out2", p2, k < 16 ? 128'h0 : ONE_OUT2);
      chk("run_out1", o1, k < 272 ? 128'h0 : g1);
      chk("run_out2", o2, k < 272 ? 128'h0 : g2);
    end
    chk("bit7_out1", o1 & BIT7, '0);
    chk("bit7_out2", o2 & BIT7, '0);
    // scenario 4: hold after completion
    n = 1900 + $urandom_range(0, 200);
    for (int j = 0; j < n; j++) begin
      @(posedge clk);
      #1;
      if (j % 97 == 0 || j == n - 1) begin
        chk("hold_out1", o1, g1);
        chk("hold_out2", o2, g2);
      end
    end
    // scenario 5: asynchronous reset mid-run at a randomized cycle
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      n = (r == 0) ? 100 : $urandom_range(1, 271);
      repeat (n) @(posedge clk);
      #($urandom_range(5, 40));
      rst = 1'b0;
      #1;
      chk("mid_rst_out1", o1, '0);
      chk("mid_rst_out2", o2, '0);
      repeat ($urandom_range(1, 4)) @(negedge clk);
      rst = 1'b1;
      run_check("restart");
    end
    // scenario 6: reset while DONE
    repeat ($urandom_range(1, 30)) @(posedge clk);
    #($urandom_range(5, 40));
    rst = 1'b0;
    #1;
    chk("done_rst_out1", o1, '0);
    chk("done_rst_out2", o2, '0);
    chk("done_rst_one_out1", p1, '0);
    @(negedge clk);
    rst = 1'b1;
    run_check("after_done");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
